// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register datapath: direction encodings
// and the state enums used by the serial receiver.
package shift_pkg;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } asm_state_t;

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH bit counter. The wrap strobe flags the increment that
// returns the count to zero, i.e. the bit that completes a word.
module shift_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     wrap
);

    localparam int CW = $clog2(WIDTH);

    assign wrap = inc && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words MSB- or
// LSB-first into a one-entry valid/ready buffer with a sticky overrun flag.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_bit,
    input  logic                     s_valid,
    input  logic                     lsb_first,
    input  logic                     clear,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    asm_state_t       st;
    buf_state_t       buf_st;
    logic             dir;
    logic             dir_eff;
    logic             accept;
    logic             wrap;
    logic             done;
    logic             handshake;

    // The first bit of a word uses the live direction input; later bits use the latch.
    assign accept    = s_valid && !clear;
    assign dir_eff   = (st == ST_IDLE) ? lsb_first : dir;
    assign shifted   = (dir_eff == DIR_LSB_FIRST) ? {s_bit, sr[WIDTH-1:1]}
                                                  : {sr[WIDTH-2:0], s_bit};
    assign done      = accept && wrap;
    assign handshake = (buf_st == BUF_FULL) && q_ready;

    shift_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (clear),
        .cnt  (bit_cnt),
        .wrap (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= ST_IDLE;
            dir <= DIR_MSB_FIRST;
            sr  <= '0;
        end else if (clear) begin
            st <= ST_IDLE;
            sr <= '0;
        end else if (s_valid) begin
            sr <= shifted;
            case (st)
                ST_IDLE: begin
                    dir <= lsb_first;
                    st  <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (wrap) begin
                        st <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // A completing word may replace a buffered one only if that one drains on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_st  <= BUF_EMPTY;
            q       <= '0;
            overrun <= 1'b0;
        end else begin
            if (done) begin
                if (buf_st == BUF_EMPTY || q_ready) begin
                    q      <= shifted;
                    buf_st <= BUF_FULL;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (handshake) begin
                buf_st <= BUF_EMPTY;
            end
            if (clear) begin
                overrun <= 1'b0;
            end
        end
    end

    assign q_valid = (buf_st == BUF_FULL);
    assign busy    = (st == ST_SHIFT);

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer: directed scenarios plus a
// randomized run against a word-level reference model.
module tb_shift_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_bit = 1'b0;
    logic          s_valid = 1'b0;
    logic          lsb_first = 1'b0;
    logic          clear = 1'b0;
    logic          q_ready = 1'b0;
    logic [W-1:0]  q;
    logic          q_valid;
    logic          busy;
    logic [CW-1:0] bit_cnt;
    logic          overrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: the bits of the word in arrival order, and the buffer contents.
    bit            m_bits[$];
    bit            m_dir;
    logic [W-1:0]  m_q;
    bit            m_valid;
    bit            m_ov;

    shift_deserializer #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_bit     (s_bit),
        .s_valid   (s_valid),
        .lsb_first (lsb_first),
        .clear     (clear),
        .q         (q),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] assemble(input bit lsb);
        int val = 0;
        for (int i = 0; i < W; i++) begin
            if (m_bits[i]) val += lsb ? (1 << i) : (1 << (W - 1 - i));
        end
        return W'(val);
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_q     = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
    endtask

    // Applies the inputs held over this edge to the model.
    task automatic model_edge();
        bit           done = 1'b0;
        bit           hs;
        logic [W-1:0] word = '0;
        hs = m_valid && q_ready;
        if (clear) begin
            m_bits.delete();
            m_ov = 1'b0;
        end else if (s_valid) begin
            if (m_bits.size() == 0) m_dir = lsb_first;
            m_bits.push_back(s_bit);
            if (m_bits.size() == W) begin
                word = assemble(m_dir);
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || q_ready) begin
                m_q     = word;
                m_valid = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_bit(input logic b, input logic lsb);
        s_valid   = 1'b1;
        s_bit     = b;
        lsb_first = lsb;
        step();
        s_valid   = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic lsb);
        for (int i = 0; i < W; i++) begin
            send_bit(lsb ? w[i] : w[W-1-i], lsb);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #12;
        vec_cnt++;
        if (q !== '0 || q_valid !== 1'b0 || busy !== 1'b0 || bit_cnt !== '0 || overrun !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL reset_outputs: q=%h v=%b busy=%b cnt=%0d ov=%b, expected all zero",
                     q, q_valid, busy, bit_cnt, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_msb_word();
        q_ready = 1'b1;
        send_word(8'hA5, 1'b0);
        vec_cnt++;
        if (q !== 8'hA5 || q_valid !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL msb_word: q=%h v=%b, expected q=a5 v=1", q, q_valid);
        end
        vec_cnt++;
        if (busy !== 1'b0 || bit_cnt !== '0) begin
            err_cnt++;
            $display("[TB] FAIL msb_word_idle: busy=%b cnt=%0d, expected busy=0 cnt=0", busy, bit_cnt);
        end
    endtask

    task automatic test_lsb_gaps();
        bit seq[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
        q_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_bit(seq[i], i == 0);
            if (i == 3) begin
                idle(3);
                vec_cnt++;
                if (busy !== 1'b1 || bit_cnt !== CW'(4)) begin
                    err_cnt++;
                    $display("[TB] FAIL lsb_gap_hold: busy=%b cnt=%0d, expected busy=1 cnt=4", busy, bit_cnt);
                end
            end
        end
        vec_cnt++;
        if (q !== 8'h1E || q_valid !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL lsb_word: q=%h v=%b, expected q=1e v=1", q, q_valid);
        end
    endtask

    task automatic test_overrun();
        q_ready = 1'b1;
        idle(1);
        q_ready = 1'b0;
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        vec_cnt++;
        if (q !== 8'h12 || q_valid !== 1'b1 || overrun !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL overrun_hold: q=%h v=%b ov=%b, expected q=12 v=1 ov=1", q, q_valid, overrun);
        end
        q_ready = 1'b1;
        step();
        q_ready = 1'b0;
        idle(2);
        vec_cnt++;
        if (q_valid !== 1'b0 || overrun !== 1'b1 || q !== 8'h12) begin
            err_cnt++;
            $display("[TB] FAIL overrun_drain: q=%h v=%b ov=%b, expected q=12 v=0 ov=1", q, q_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        step();
        clear = 1'b0;
        q_ready = 1'b0;
        send_word(8'h55, 1'b0);
        vec_cnt++;
        if (q !== 8'h55 || q_valid !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL b2b_first: q=%h v=%b, expected q=55 v=1", q, q_valid);
        end
        for (int i = 0; i < W; i++) begin
            q_ready = (i == W - 1);
            send_bit(((8'hAA >> (W - 1 - i)) & 1) != 0, 1'b0);
        end
        q_ready = 1'b0;
        vec_cnt++;
        if (q !== 8'hAA || q_valid !== 1'b1 || overrun !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL b2b_replace: q=%h v=%b ov=%b, expected q=aa v=1 ov=0", q, q_valid, overrun);
        end
    endtask

    task automatic test_clear();
        q_ready = 1'b0;
        send_word(8'hF0, 1'b0);
        vec_cnt++;
        if (overrun !== 1'b1 || q !== 8'hAA) begin
            err_cnt++;
            $display("[TB] FAIL clear_setup: q=%h ov=%b, expected q=aa ov=1", q, overrun);
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        clear = 1'b1;
        send_bit(1'b1, 1'b1);
        clear = 1'b0;
        vec_cnt++;
        if (overrun !== 1'b0 || busy !== 1'b0 || bit_cnt !== '0 || q_valid !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL clear_effect: ov=%b busy=%b cnt=%0d v=%b, expected ov=0 busy=0 cnt=0 v=1",
                     overrun, busy, bit_cnt, q_valid);
        end
        q_ready = 1'b1;
        send_word(8'hC3, 1'b0);
        vec_cnt++;
        if (q !== 8'hC3 || q_valid !== 1'b1 || overrun !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL clear_word: q=%h v=%b ov=%b, expected q=c3 v=1 ov=0", q, q_valid, overrun);
        end
    endtask

    task automatic test_async_reset();
        q_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        #2;
        vec_cnt++;
        if (q !== '0 || q_valid !== 1'b0 || busy !== 1'b0 || bit_cnt !== '0 || overrun !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL async_reset: q=%h v=%b busy=%b cnt=%0d ov=%b, expected all zero",
                     q, q_valid, busy, bit_cnt, overrun);
        end
        #1;
        rst = 1'b0;
        model_reset();
        send_word(8'h81, 1'b0);
        vec_cnt++;
        if (q !== 8'h81 || q_valid !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL post_reset_word: q=%h v=%b, expected q=81 v=1", q, q_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            s_valid   = ($urandom_range(0, 9) < 7);
            s_bit     = $urandom_range(0, 1);
            lsb_first = $urandom_range(0, 1);
            q_ready   = ($urandom_range(0, 9) < 4);
            clear     = ($urandom_range(0, 39) == 0);
            step();
            vec_cnt++;
            if (q !== m_q || q_valid !== m_valid) begin
                err_cnt++;
                $display("[TB] FAIL rand_buffer[%0d]: q=%h v=%b, expected q=%h v=%b", n, q, q_valid, m_q, m_valid);
            end
            vec_cnt++;
            if (overrun !== m_ov || bit_cnt !== CW'(m_bits.size()) || busy !== (m_bits.size() != 0)) begin
                err_cnt++;
                $display("[TB] FAIL rand_status[%0d]: ov=%b cnt=%0d busy=%b, expected ov=%b cnt=%0d busy=%b",
                         n, overrun, bit_cnt, busy, m_ov, m_bits.size(), m_bits.size() != 0);
            end
        end
        s_valid = 1'b0;
        clear   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_word();
        test_lsb_gaps();
        test_overrun();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in, parallel-out receiver that sits on the reader side of the team's shift-register datapath. It accumulates a qualified serial bitstream into WIDTH-bit words, MSB-first or LSB-first, selected per word. Each completed word goes into a one-entry output buffer with a valid/ready handshake. If a word completes while the buffer is still full, the new word is dropped and a sticky overrun flag is set.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_bit  in  1  serial data bit.
- s_valid  in  1  s_bit is accepted on this edge. There is no input backpressure.
- lsb_first  in  1  0 = MSB-first, 1 = LSB-first. Sampled only on the first bit of a word.
- clear  in  1  synchronous resync. Discards the partial word and clears overrun.
- q  out  WIDTH  assembled word, held while q_valid is high.
- q_valid  out  1  output buffer full.
- q_ready  in  1  consumer accepts q when q_valid && q_ready.
- busy  out  1  partial word in progress (bit_cnt != 0).
- bit_cnt  out  $clog2(WIDTH)  bits accepted in the current word.
- overrun  out  1  sticky; a completed word was dropped.

## Operation
- Assembly FSM has two states:
  - IDLE (bit_cnt = 0): an s_valid bit latches dir = lsb_first, shifts in the bit, sets bit_cnt = 1 and moves to SHIFT.
  - SHIFT: each s_valid bit shifts in and increments bit_cnt. Direction changes mid-word are ignored.
- Shift rules:
  - MSB-first: sr <= {sr[WIDTH-2:0], s_bit}.
  - LSB-first: sr <= {s_bit, sr[WIDTH-1:1]}.
- Word completion: an s_valid bit arrives while bit_cnt = WIDTH-1.
  - bit_cnt wraps to 0 and the FSM returns to IDLE.
  - The completed word is sr with the final bit shifted in, in the latched direction.
- Output buffer has two states, EMPTY and FULL.
  - Completion while EMPTY, or while FULL with q_valid && q_ready in the same cycle: q <= completed word, q_valid = 1.
  - Completion while FULL with no handshake: the word is dropped, overrun <= 1, and q is unchanged.
  - Handshake with no completion: q_valid <= 0. q holds its last value.
- clear:
  - Resets sr, bit_cnt and overrun, and returns the FSM to IDLE.
  - Does not touch q or q_valid.
  - Takes priority over s_valid in the same cycle; that bit is discarded.
  - Takes priority over overrun set.
- Gaps in s_valid are legal at any point. State holds while s_valid = 0.

## Timing
- Reset values: q = 0, q_valid = 0, busy = 0, bit_cnt = 0, overrun = 0, sr = 0, FSM IDLE, buffer EMPTY.
- Reset asserted mid-word: all state returns to reset values immediately. The partial word is lost.
- Latency: the final bit accepted at edge N gives q/q_valid valid after edge N. The consumer can take it on edge N+1.
- Throughput: one word per WIDTH accepted bits, back-to-back with no dead cycle.
- q and q_valid are stable while q_valid = 1 and q_ready = 0.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package shift_pkg holds:
  - DIR_MSB_FIRST = 1'b0 and DIR_LSB_FIRST = 1'b1.
  - Assembly state enum {ST_IDLE, ST_SHIFT}.
  - Output buffer state enum {BUF_EMPTY, BUF_FULL}.
- One sub-module, shift_bit_counter: a modulo-WIDTH counter with inc, clr and a wrap strobe.
- The top level holds sr, the direction latch, the output buffer and overrun.

## Test plan
- MSB-first word: WIDTH = 8, lsb_first = 0, q_ready = 1, bits 1,0,1,0,0,1,0,1 on eight consecutive cycles -> q = 0xA5 and q_valid = 1 after the 8th edge; busy = 0; bit_cnt = 0.
- LSB-first word with gaps and a direction flip: lsb_first = 1 on the first bit, then 0. Bits 0,1,1,1,1,0,0,0 with idle cycles between bits 3 and 4 -> q = 0x1E.
- Backpressure and overrun: q_ready = 0, words 0x12 then 0x34 -> q stays 0x12 and overrun = 1. Then q_ready = 1 for one cycle -> q_valid = 0. Overrun stays 1 until clear.
- Simultaneous drain and completion: q_valid = 1 holding 0x55, and q_ready = 1 on the same edge as the final bit of 0xAA -> q = 0xAA, q_valid stays 1, overrun = 0.
- clear mid-word: 3 bits, then clear asserted together with s_valid, then 8 bits of 0xC3 MSB-first -> q = 0xC3. The 3 earlier bits and the discarded bit have no effect. Overrun is cleared.
- Asynchronous reset mid-word: rst pulsed between edges after 5 bits -> all outputs 0 immediately. The next 8 bits of 0x81 give q = 0x81.
